// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types, widths and helpers for the A2D round-robin interface.
//   state_t      - conversion sequencer states
//   spi_state_t  - SPI master phase
//   CH_*         - A2D channel numbers for each reading
//   cmd_word()   - forms the 16-bit A2D command for a channel
//   rr_chnl()    - maps the round-robin pointer to its A2D channel
package a2d_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 12;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned RR_W   = 2;
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_XFER,
        SPI_BACK
    } spi_state_t;

    localparam logic [CH_W-1:0] CH_LFT   = 3'd0;
    localparam logic [CH_W-1:0] CH_RGHT  = 3'd4;
    localparam logic [CH_W-1:0] CH_STEER = 3'd5;
    localparam logic [CH_W-1:0] CH_BATT  = 3'd6;

    // A2D command: channel number in bits [13:11], everything else zero.
    function automatic logic [DATA_W-1:0] cmd_word(input logic [CH_W-1:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

    // Round-robin slot to A2D channel.
    function automatic logic [CH_W-1:0] rr_chnl(input logic [RR_W-1:0] rr);
        logic [CH_W-1:0] ch;
        case (rr)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mnrch.sv
// spi_mnrch: 16-bit MSB-first SPI master (mode 3 style, SCLK idles high).
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   start       - begin a transaction (ignored while busy)
//   tx_data     - word shifted out on MOSI
//   rx_data     - word shifted in from MISO, valid from done onward
//   done        - one-clk pulse coincident with SS_n rising
//   SS_n, SCLK, MOSI - SPI outputs; MISO - SPI input
module spi_mnrch
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned     CNT_W    = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCLK_DIV - 1);
    // Last count before the MSB sets, i.e. the clk that produces SCLK rise.
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    spi_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;

    // SCLK is the divider MSB; holding cnt at CNT_HALF keeps it high when idle.
    assign SCLK    = cnt[CNT_W-1];
    assign rx_data = shreg;

    // Transaction sequencing: front porch, 16 bit periods, back porch.
    // One shift register serves both directions: a fall shifts the next TX
    // bit out to MOSI and frees bit 0, which the following rise fills from MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SPI_IDLE;
            cnt     <= CNT_HALF;
            shreg   <= '0;
            bit_cnt <= '0;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (start) begin
                        SS_n    <= 1'b0;
                        cnt     <= CNT_HALF;
                        shreg   <= tx_data;
                        bit_cnt <= '0;
                        state   <= SPI_XFER;
                    end
                end
                SPI_XFER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_MAX) begin
                        MOSI  <= shreg[DATA_W-1];
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
                    end else if (cnt == CNT_RISE) begin
                        shreg[0] <= MISO;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= SPI_BACK;
                        end
                    end
                end
                SPI_BACK: begin
                    // SCLK stays high: cnt runs HALF..MAX, never wrapping to 0.
                    if (cnt == CNT_MAX) begin
                        cnt   <= CNT_HALF;
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= SPI_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SPI_IDLE;
                    cnt   <= CNT_HALF;
                    SS_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin front end for the 8-channel SPI A2D converter.
// Each nxt pulse runs a command transaction then a read transaction and
// latches the 12-bit result into the reading for the current slot.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   nxt        - one-clk request for the next round-robin conversion
//   lft_ld     - channel 0 reading      rght_ld - channel 4 reading
//   steer_pot  - channel 5 reading      batt    - channel 6 reading
//   SS_n, SCLK, MOSI, MISO - SPI bus to the A2D
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             nxt,
    output logic [RES_W-1:0] lft_ld,
    output logic [RES_W-1:0] rght_ld,
    output logic [RES_W-1:0] steer_pot,
    output logic [RES_W-1:0] batt,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    state_t            state;
    logic [RR_W-1:0]   rr;
    logic              start;
    logic              done;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic [RES_W-1:0]  rx_res;

    // rr only changes in IDLE, so the command is stable across both transactions.
    assign tx_data = cmd_word(rr_chnl(rr));
    // Upper nibble of the read word carries no conversion data.
    assign rx_res  = RES_W'(rx_data);

    spi_mnrch #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .done    (done),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // Conversion sequencer; start is a registered one-clk pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            start     <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt) begin
                        start <= 1'b1;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    start <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    if (done) begin
                        case (rr)
                            2'd0:    lft_ld    <= rx_res;
                            2'd1:    rght_ld   <= rx_res;
                            2'd2:    steer_pot <= rx_res;
                            default: batt      <= rx_res;
                        endcase
                        rr    <= rr + RR_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: scoreboard bench for a2d_intf with a behavioural A2D slave.
// Stimulus pushes expected command words and reading updates into queues;
// independent monitors pop and compare when the DUT finishes a transaction
// or changes a reading.
module tb_a2d_intf;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt   = 1'b0;
    logic        MISO  = 1'b0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        SS_n, SCLK, MOSI;

    a2d_intf #(.SCLK_DIV(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic [1:0]  idx;
        logic [11:0] val;
    } rd_t;

    logic [15:0] exp_cmd_q[$];
    rd_t         exp_rd_q[$];

    // ---------------- A2D slave model ----------------
    logic [11:0] aval [8];
    logic [15:0] cap;
    logic [15:0] resp;
    logic [2:0]  prev_ch = 3'd0;
    int          falls   = 0;
    int          bit_idx = 15;
    int          xfer_cnt = 0;

    // Each transaction returns the conversion of the previously commanded channel.
    always @(negedge SS_n) begin
        cap     = 16'h0000;
        falls   = 0;
        bit_idx = 15;
        resp    = {4'hA, aval[prev_ch]};
    end

    always @(negedge SCLK) begin
        if (!SS_n && rst_n) begin
            falls++;
            if (bit_idx >= 0) begin
                MISO = resp[bit_idx];
                bit_idx--;
            end
        end
    end

    always @(posedge SCLK) begin
        if (!SS_n && rst_n) cap = {cap[14:0], MOSI};
    end

    // Command monitor: one pop per completed SS_n window.
    always @(posedge SS_n) begin
        if (rst_n) begin
            xfer_cnt++;
            check("sclk_falls", falls, 16);
            if (exp_cmd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cmd: unexpected transaction carrying %h, none expected", cap);
            end else begin
                check("cmd", cap, exp_cmd_q.pop_front());
            end
            prev_ch = cap[13:11];
        end
    end

    // ---------------- reading monitor ----------------
    logic [11:0] shadow [4];
    logic [47:0] cur_rd;
    logic [47:0] prev_rd = '0;
    rd_t         rd_e;

    always @(negedge clk) begin
        cur_rd = {lft_ld, rght_ld, steer_pot, batt};
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) shadow[i] = 12'h000;
            prev_rd = cur_rd;
        end else if (cur_rd !== prev_rd) begin
            if (exp_rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL reading: unexpected update to %h", cur_rd);
            end else begin
                rd_e = exp_rd_q.pop_front();
                shadow[rd_e.idx] = rd_e.val;
                check("lft_ld", lft_ld, shadow[0]);
                check("rght_ld", rght_ld, shadow[1]);
                check("steer_pot", steer_pot, shadow[2]);
                check("batt", batt, shadow[3]);
            end
            prev_rd = cur_rd;
        end
    end

    // ---------------- SPI timing monitor ----------------
    logic p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
    int   pcnt = 0, gap = 0, edge_cnt = 0;
    bit   in_front = 0, seen_rise = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_ss !== SS_n || p_sclk !== SCLK) edge_cnt++;
            if (SS_n) gap++;
            if (p_ss && !SS_n) begin
                pcnt     = 0;
                in_front = 1;
                if (seen_rise) check("ss_gap_ge1", (gap >= 1), 1);
            end else begin
                pcnt++;
            end
            if (in_front && p_sclk && !SCLK) begin
                check("front_porch", pcnt, 16);
                in_front = 0;
            end
            if (!SS_n && !p_sclk && SCLK) begin
                check("mosi_stable", MOSI, p_mosi);
                pcnt = 0;
            end
            if (!p_ss && SS_n) begin
                check("back_porch", pcnt, 16);
                gap       = 0;
                seen_rise = 1;
            end
        end else begin
            in_front  = 0;
            seen_rise = 0;
        end
        p_ss   = SS_n;
        p_sclk = SCLK;
        p_mosi = MOSI;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_nxt();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("xfer_count", xfer_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One full conversion with hand-computed command and result.
    task automatic conv(input logic [1:0] idx, input logic [11:0] v, input logic [15:0] cmd);
        int  base = xfer_cnt;
        rd_t r;
        aval[cmd[13:11]] = v;
        exp_cmd_q.push_back(cmd);
        exp_cmd_q.push_back(cmd);
        r.idx = idx;
        r.val = v;
        exp_rd_q.push_back(r);
        pulse_nxt();
        wait_xfers(base + 2);
        repeat (3) @(negedge clk);
    endtask

    int  base;
    int  n;
    int  e0;
    rd_t r0;

    initial begin
        for (int i = 0; i < 8; i++) aval[i] = 12'hFFF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lft", lft_ld, 12'h000);
        check("rst_rght", rght_ld, 12'h000);
        check("rst_steer", steer_pot, 12'h000);
        check("rst_batt", batt, 12'h000);
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_sclk", SCLK, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        rst_n = 1'b1;

        // Idle: no SPI activity without nxt.
        e0 = edge_cnt;
        repeat (1000) @(negedge clk);
        check("idle_edges", edge_cnt - e0, 0);
        check("idle_ss_n", SS_n, 1'b1);
        check("idle_sclk", SCLK, 1'b1);
        check("idle_readings", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);

        // First conversion from reset lands in lft_ld only.
        conv(2'd0, 12'hA5C, 16'h0000);
        check("first_lft", lft_ld, 12'hA5C);
        check("first_others", {rght_ld, steer_pot, batt}, 36'h0);

        // Full round-robin sweep then wrap.
        do_reset();
        conv(2'd0, 12'h111, 16'h0000);
        conv(2'd1, 12'h444, 16'h2000);
        conv(2'd2, 12'h555, 16'h2800);
        conv(2'd3, 12'h666, 16'h3000);
        conv(2'd0, 12'h777, 16'h0000);
        check("wrap_lft", lft_ld, 12'h777);
        check("wrap_rght", rght_ld, 12'h444);

        // Extra nxt in CMD, in READ and on the READ->IDLE cycle are dropped.
        aval[4] = 12'h9AB;
        exp_cmd_q.push_back(16'h2000);
        exp_cmd_q.push_back(16'h2000);
        r0.idx = 2'd1;
        r0.val = 12'h9AB;
        exp_rd_q.push_back(r0);
        base = xfer_cnt;
        pulse_nxt();
        repeat (100) @(negedge clk);
        pulse_nxt();
        wait_xfers(base + 1);
        repeat (100) @(negedge clk);
        pulse_nxt();
        n = 0;
        while (SS_n !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        repeat (300) @(negedge clk);
        check("no_extra_xfer", xfer_cnt, base + 2);
        check("extra_rght", rght_ld, 12'h9AB);
        conv(2'd2, 12'h0F0, 16'h2800);
        conv(2'd3, 12'h321, 16'h3000);
        conv(2'd0, 12'h456, 16'h0000);

        // Reset in the middle of the rght_ld read transaction.
        aval[4] = 12'hBEE;
        exp_cmd_q.push_back(16'h2000);
        base = xfer_cnt;
        pulse_nxt();
        wait_xfers(base + 1);
        repeat (200) @(negedge clk);
        check("tx2_active", SS_n, 1'b0);
        check("rght_old_before_rst", rght_ld, 12'h9AB);
        #3 rst_n = 1'b0;
        #1;
        check("abort_ss_n", SS_n, 1'b1);
        check("abort_rght", rght_ld, 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_xfer", xfer_cnt, base + 1);
        conv(2'd0, 12'h135, 16'h0000);
        check("post_rst_lft", lft_ld, 12'h135);
        check("post_rst_rght", rght_ld, 12'h000);

        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("rd_q_empty", exp_rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
